// File: rtl/if_prefetch_queue.sv
// ============================================================================
// Module   : if_prefetch_queue
// Summary  : Instruction prefetch FIFO with credit-limited fetch issue and
//            redirect flush. Define PFQ_BYPASS_EN for the empty-queue bypass.
// Revision : 1.0
// ============================================================================
`default_nettype none

module if_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic                       imem_req,
    output logic [31:0]                imem_addr,
    input  logic                       imem_gnt,
    input  logic                       imem_rvalid,
    input  logic [31:0]                imem_rdata,
    output logic                       out_valid,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_instr,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] q_count
);

    localparam int unsigned c_PW = $clog2(DEPTH);
    localparam int unsigned c_CW = $clog2(DEPTH+1);

    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_resp_pc;
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic [c_CW-1:0] r_inflight;
    logic [c_CW-1:0] r_discard;
    logic [31:0]     r_mem_pc    [DEPTH];
    logic [31:0]     r_mem_instr [DEPTH];

    logic            w_credit_ok;
    logic            w_issue;
    logic            w_fresh;
    logic            w_empty;
    logic            w_bypass;
    logic            w_push;
    logic            w_pop;
    logic            w_rsp_dec;
    logic [c_CW-1:0] w_inflight_nxt;
    logic [c_CW-1:0] w_discard_nxt;

    // In-flight requests (including ones to be discarded) hold a credit.
    assign w_credit_ok = ({1'b0, r_count} + {1'b0, r_inflight}) < (c_CW+1)'(DEPTH);
    assign imem_req    = !reset && !redirect && w_credit_ok;
    assign imem_addr   = r_fetch_pc;
    assign w_issue     = imem_req && imem_gnt;

    assign w_empty     = (r_count == '0);
    assign w_fresh     = imem_rvalid && (r_discard == '0) && !redirect;

`ifdef PFQ_BYPASS_EN
    assign w_bypass    = w_empty && w_fresh;
`else
    assign w_bypass    = 1'b0;
`endif

    assign out_valid   = !reset && (!w_empty || w_bypass);
    assign out_pc      = w_bypass ? r_resp_pc  : (w_empty ? 32'h0 : r_mem_pc[r_rd_ptr]);
    assign out_instr   = w_bypass ? imem_rdata : (w_empty ? 32'h0 : r_mem_instr[r_rd_ptr]);
    assign q_count     = r_count;

    assign w_pop       = out_valid && out_ready && !redirect && !w_bypass;
    assign w_push      = w_fresh && !(w_bypass && out_ready);

    always_comb begin
        w_rsp_dec      = imem_rvalid && (r_inflight != '0);
        w_inflight_nxt = r_inflight;
        w_discard_nxt  = r_discard;
        if (redirect) begin
            // Everything still outstanding after this edge belongs to the old stream.
            w_inflight_nxt = r_inflight - c_CW'(w_rsp_dec);
            w_discard_nxt  = w_inflight_nxt;
        end else begin
            w_inflight_nxt = r_inflight + c_CW'(w_issue) - c_CW'(w_rsp_dec);
            if (w_rsp_dec && (r_discard != '0)) begin
                w_discard_nxt = r_discard - c_CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_discard  <= '0;
        end else begin
            r_inflight <= w_inflight_nxt;
            r_discard  <= w_discard_nxt;
            if (redirect) begin
                r_fetch_pc <= redirect_pc;
                r_resp_pc  <= redirect_pc;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
            end else begin
                if (w_issue) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                // Responses return in order, so the tag is just a running PC.
                if (w_fresh) begin
                    r_resp_pc <= r_resp_pc + 32'd4;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PW'(1);
                end
                r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem_pc[r_wr_ptr]    <= r_resp_pc;
            r_mem_instr[r_wr_ptr] <= imem_rdata;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_if_prefetch_queue.sv
// ============================================================================
// Module   : tb_if_prefetch_queue
// Summary  : Self-checking bench for if_prefetch_queue with an in-order
//            variable-latency memory and an epoch-based reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_if_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready = 1'b0;
    logic [2:0]  q_count;

    if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
        .out_ready(out_ready), .q_count(q_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; int epoch; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    typedef struct { logic rdy; logic req; logic [31:0] addr; logic valid; logic [31:0] pc; logic [2:0] q; } vec_t;

    mreq_t       mq[$];
    ent_t        mf[$];
    logic [31:0] m_fetch = RESET_PC;
    int          m_epoch = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          gnt_pct = 100;
    int          lat_lo = 1;
    int          lat_hi = 1;
    int          checks = 0;
    int          passes = 0;
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_instr;
    logic [2:0]  s_q;
    vec_t        tv[21];

    function automatic logic [31:0] img(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic model_reset();
        mq.delete();
        mf.delete();
        m_fetch  = RESET_PC;
        m_epoch++;
        last_due = cyc;
    endtask

    // One clock cycle: drive at negedge, check at negedge+1, update model, return at next negedge.
    task automatic step(input logic rd, input logic [31:0] rpc, input logic rdy);
        mreq_t       r;
        ent_t        dropped;
        logic        got, fresh, exp_req, exp_valid, byp;
        logic [31:0] exp_pc, exp_instr;
        int          n_out, due;
        r           = '{32'h0, 0, 0};
        redirect    = rd;
        redirect_pc = rpc;
        out_ready   = rdy;
        imem_gnt    = ($urandom_range(99) < gnt_pct);
        n_out       = mq.size();
        got         = 1'b0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            r   = mq.pop_front();
            got = 1'b1;
        end
        imem_rvalid = got;
        imem_rdata  = got ? img(r.addr) : $urandom;
        #1;
        s_req = imem_req; s_addr = imem_addr; s_valid = out_valid;
        s_pc = out_pc; s_instr = out_instr; s_q = q_count;

        fresh   = got && (r.epoch == m_epoch) && !rd;
        exp_req = !rd && ((mf.size() + n_out) < DEPTH);
`ifdef PFQ_BYPASS_EN
        byp = fresh && (mf.size() == 0);
`else
        byp = 1'b0;
`endif
        exp_valid = byp || (mf.size() > 0);
        exp_pc    = byp ? r.addr      : (mf.size() > 0 ? mf[0].pc    : 32'h0);
        exp_instr = byp ? img(r.addr) : (mf.size() > 0 ? mf[0].instr : 32'h0);

        chk("imem_req", imem_req, exp_req);
        if (exp_req) chk("imem_addr", imem_addr, m_fetch);
        chk("q_count", q_count, mf.size());
        chk("out_valid", out_valid, exp_valid);
        if (exp_valid) begin
            chk("out_pc", out_pc, exp_pc);
            chk("out_instr", out_instr, exp_instr);
        end

        if (imem_req && imem_gnt) begin
            due = cyc + $urandom_range(lat_hi, lat_lo);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{imem_addr, due, m_epoch});
            m_fetch = m_fetch + 32'd4;
        end
        if (rd) begin
            mf.delete();
            m_fetch = rpc;
            m_epoch++;
        end else if (!(byp && rdy)) begin
            if (exp_valid && rdy) dropped = mf.pop_front();
            if (fresh) mf.push_back('{r.addr, img(r.addr)});
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        imem_rvalid = 1'b0;
        redirect    = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_first(input string nm, input logic [31:0] exp);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            step(1'b0, 32'h0, 1'b1);
            if (s_valid) begin
                chk(nm, s_pc, exp);
                seen = 1'b1;
            end
        end
        if (!seen) begin
            checks++;
            $display("FAIL %s: timeout, got no out_valid expected pc %h", nm, exp);
        end
    endtask

    initial begin
        logic [31:0] wrap_exp[3];
        int          n;

        tv[0]  = '{1, 1, 32'h00, 0, 32'h00, 0};
        tv[1]  = '{1, 1, 32'h04, 0, 32'h00, 0};
        tv[2]  = '{1, 1, 32'h08, 1, 32'h00, 1};
        tv[3]  = '{1, 1, 32'h0C, 1, 32'h04, 1};
        tv[4]  = '{1, 1, 32'h10, 1, 32'h08, 1};
        tv[5]  = '{1, 1, 32'h14, 1, 32'h0C, 1};
        tv[6]  = '{0, 1, 32'h18, 1, 32'h10, 1};
        tv[7]  = '{0, 1, 32'h1C, 1, 32'h10, 2};
        tv[8]  = '{0, 0, 32'h20, 1, 32'h10, 3};
        tv[9]  = '{0, 0, 32'h20, 1, 32'h10, 4};
        tv[10] = '{0, 0, 32'h20, 1, 32'h10, 4};
        tv[11] = '{0, 0, 32'h20, 1, 32'h10, 4};
        tv[12] = '{0, 0, 32'h20, 1, 32'h10, 4};
        tv[13] = '{0, 0, 32'h20, 1, 32'h10, 4};
        tv[14] = '{0, 0, 32'h20, 1, 32'h10, 4};
        tv[15] = '{0, 0, 32'h20, 1, 32'h10, 4};
        tv[16] = '{1, 0, 32'h20, 1, 32'h10, 4};
        tv[17] = '{1, 1, 32'h20, 1, 32'h14, 3};
        tv[18] = '{1, 1, 32'h24, 1, 32'h18, 2};
        tv[19] = '{1, 1, 32'h28, 1, 32'h1C, 2};
        tv[20] = '{1, 1, 32'h2C, 1, 32'h20, 2};

        model_reset();
        repeat (2) @(negedge clk);
        chk("reset imem_req", imem_req, 1'b0);
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset q_count", q_count, 3'd0);
        chk("reset out_pc", out_pc, 32'h0);
        chk("reset out_instr", out_instr, 32'h0);
        reset = 1'b0;

        // Streaming from reset, then a 10-cycle decode stall and drain.
        for (int i = 0; i < 21; i++) begin
            step(1'b0, 32'h0, tv[i].rdy);
`ifndef PFQ_BYPASS_EN
            chk("tbl imem_req", s_req, tv[i].req);
            if (tv[i].req) chk("tbl imem_addr", s_addr, tv[i].addr);
            chk("tbl q_count", s_q, tv[i].q);
            chk("tbl out_valid", s_valid, tv[i].valid);
            if (tv[i].valid) begin
                chk("tbl out_pc", s_pc, tv[i].pc);
                chk("tbl out_instr", s_instr, img(tv[i].pc));
            end
`endif
        end

        // Latency 3: redirect with two stale requests in flight.
        do_reset();
        lat_lo = 3; lat_hi = 3;
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h100, 1'b1);
        wait_first("redirect lat3 first pc", 32'h100);

        // Redirect coinciding with a response and a pop request.
        do_reset();
        lat_lo = 1; lat_hi = 1;
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h200, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        chk("redir+rvalid q_count", s_q, 3'd0);
        chk("redir+rvalid req", s_req, 1'b1);
        chk("redir+rvalid addr", s_addr, 32'h200);
        wait_first("redir+rvalid first pc", 32'h200);

        // Fetch PC wrap.
        step(1'b1, 32'hFFFF_FFF8, 1'b1);
        wrap_exp[0] = 32'hFFFF_FFF8; wrap_exp[1] = 32'hFFFF_FFFC; wrap_exp[2] = 32'h0;
        n = 0;
        for (int i = 0; i < 40 && n < 3; i++) begin
            step(1'b0, 32'h0, 1'b1);
            if (s_valid) begin
                chk("wrap pc", s_pc, wrap_exp[n]);
                n++;
            end
        end
        if (n < 3) begin
            checks++;
            $display("FAIL wrap: timeout, got %0d pops expected 3", n);
        end

        // Asynchronous reset mid-stream.
        lat_lo = 3; lat_hi = 3;
        n = 0;
        for (int i = 0; i < 20 && n == 0; i++) begin
            step(1'b0, 32'h0, 1'b0);
            if (s_q >= 3'd2) n = 1;
        end
        #2;
        reset       = 1'b1;
        imem_rvalid = 1'b0;
        #1;
        chk("async reset out_valid", out_valid, 1'b0);
        chk("async reset imem_req", imem_req, 1'b0);
        chk("async reset q_count", q_count, 3'd0);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_first("post-reset first pc", RESET_PC);

        // Randomized traffic against the reference model.
        gnt_pct = 70; lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 3000; i++) begin
            logic        rd;
            logic [31:0] rpc;
            rd  = ($urandom_range(99) < 4);
            rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 + 32'd4 * $urandom_range(3))
                                           : ($urandom & 32'hFFFF_FFFC);
            step(rd, rpc, ($urandom_range(99) < 60));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
